// File: rtl/cu_microsequencer_pkg.sv
// Shared definitions for the control-unit microsequencer: next-state modes
// and the condition-select width helper.
package cu_pkg;

   typedef enum logic [2:0] {
      NS_ENCODE = 3'd0,
      NS_INC    = 3'd1,
      NS_CJUMP  = 3'd2,
      NS_CENC   = 3'd3,
      NS_CALL   = 3'd4,
      NS_RET    = 3'd5
   } ns_mode_e;

   localparam logic [2:0] NS_RSV_LO = 3'd6;
   localparam logic [2:0] NS_RSV_HI = 3'd7;

   function automatic int cond_sel_w(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cu_microsequencer_if.sv
// ROM-side fields into the sequencer and the state/status it returns.
interface cu_microsequencer_if
   import cu_pkg::*;
#(
   parameter int STATE_W     = 7,
   parameter int COND_N      = 4,
   parameter int STACK_DEPTH = 2
) ();

   localparam int SEL_W   = cond_sel_w(COND_N);
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

   logic                 stall;
   logic [COND_N-1:0]    cond;
   logic [SEL_W-1:0]     cond_sel;
   logic                 cond_inv;
   logic [2:0]           ns_mode;
   logic [STATE_W-1:0]   target;
   logic [STATE_W-1:0]   enc_state;
   logic [STATE_W-1:0]   state;
   logic                 cond_true;
   logic [DEPTH_W-1:0]   depth;
   logic                 err;

   modport master (
      output stall, cond, cond_sel, cond_inv, ns_mode, target, enc_state,
      input  state, cond_true, depth, err
   );

   modport slave (
      input  stall, cond, cond_sel, cond_inv, ns_mode, target, enc_state,
      output state, cond_true, depth, err
   );

endinterface

// File: rtl/cu_microsequencer_ret_stack.sv
// Return-address LIFO for microcode call/return; no error tracking here,
// callers must not push when full or pop when empty.
module cu_ret_stack #(
   parameter int STATE_W     = 7,
   parameter int STACK_DEPTH = 2,
   localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [STATE_W-1:0] push_data_i,
   output logic [STATE_W-1:0] top_o,
   output logic [DEPTH_W-1:0] depth_o,
   output logic               full_o,
   output logic               empty_o
);

   logic [STATE_W-1:0] mem_q [STACK_DEPTH];
   logic [DEPTH_W-1:0] depth_q;

   assign depth_o = depth_q;
   assign full_o  = (depth_q == DEPTH_W'(STACK_DEPTH));
   assign empty_o = (depth_q == DEPTH_W'(0));

   // Occupancy counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         depth_q <= '0;
      end else if (push_i && !full_o) begin
         depth_q <= depth_q + DEPTH_W'(1);
      end else if (pop_i && !empty_o) begin
         depth_q <= depth_q - DEPTH_W'(1);
      end else begin
         depth_q <= depth_q;
      end
   end

   // Entry storage; contents after reset are don't-care.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (push_i && !full_o && (depth_q == DEPTH_W'(i))) begin
            mem_q[i] <= push_data_i;
         end else begin
            mem_q[i] <= mem_q[i];
         end
      end
   end

   // Top-of-stack read mux.
   always_comb begin
      top_o = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         top_o = (depth_q == DEPTH_W'(i + 1)) ? mem_q[i] : top_o;
      end
   end

endmodule

// File: rtl/cu_microsequencer.sv
// Next-state sequencer: selects/inverts a condition and picks the next
// control state, with call/return through a small LIFO and a sticky err.
module cu_microsequencer
   import cu_pkg::*;
#(
   parameter int               STATE_W     = 7,
   parameter int               COND_N      = 4,
   parameter int               STACK_DEPTH = 2,
   parameter logic [STATE_W-1:0] RESET_STATE = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cu_microsequencer_if.slave   bus
);

   localparam int SEL_W   = cond_sel_w(COND_N);
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

   logic [STATE_W-1:0] state_q, state_d, inc_s, top_s;
   logic               err_q, err_d;
   logic               sel_bit_s, cond_true_s;
   logic               push_s, pop_s, full_s, empty_s;
   logic [DEPTH_W-1:0] depth_s;

   cu_ret_stack #(
      .STATE_W     (STATE_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .push_i      (push_s),
      .pop_i       (pop_s),
      .push_data_i (inc_s),
      .top_o       (top_s),
      .depth_o     (depth_s),
      .full_o      (full_s),
      .empty_o     (empty_s)
   );

   // Condition select; indices past COND_N read as 0 before inversion.
   always_comb begin
      sel_bit_s = 1'b0;
      for (int i = 0; i < COND_N; i++) begin
         sel_bit_s = (bus.cond_sel == SEL_W'(i)) ? bus.cond[i] : sel_bit_s;
      end
   end

   assign cond_true_s   = sel_bit_s ^ bus.cond_inv;
   assign bus.cond_true = cond_true_s;
   assign bus.state     = state_q;
   assign bus.depth     = depth_s;
   assign bus.err       = err_q;

   // Next-state, stack control and error detection.
   always_comb begin
      inc_s   = state_q + STATE_W'(1);
      state_d = state_q;
      err_d   = err_q;
      push_s  = 1'b0;
      pop_s   = 1'b0;
      if (bus.stall) begin
         state_d = state_q;
      end else begin
         case (bus.ns_mode)
            NS_ENCODE: state_d = bus.enc_state;
            NS_INC:    state_d = inc_s;
            NS_CJUMP:  state_d = cond_true_s ? bus.target : inc_s;
            NS_CENC:   state_d = cond_true_s ? bus.enc_state : inc_s;
            NS_CALL: begin
               if (cond_true_s && !full_s) begin
                  push_s  = 1'b1;
                  state_d = bus.target;
               end else begin
                  state_d = inc_s;
                  err_d   = err_q | cond_true_s;
               end
            end
            NS_RET: begin
               if (empty_s) begin
                  state_d = RESET_STATE;
                  err_d   = 1'b1;
               end else begin
                  pop_s   = 1'b1;
                  state_d = top_s;
               end
            end
            default: begin
               state_d = inc_s;
               err_d   = 1'b1;
            end
         endcase
      end
   end

   // State and sticky error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET_STATE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_cu_microsequencer.sv
// Directed bench for cu_microsequencer with a queue-based reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_cu_microsequencer;

   localparam int STATE_W = 7;
   localparam int COND_N  = 4;
   localparam int DEPTH   = 2;

   logic clk;
   logic rst_n;

   cu_microsequencer_if #(.STATE_W(STATE_W), .COND_N(COND_N), .STACK_DEPTH(DEPTH)) bus ();

   cu_microsequencer #(
      .STATE_W     (STATE_W),
      .COND_N      (COND_N),
      .STACK_DEPTH (DEPTH),
      .RESET_STATE (7'h00)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   int m_state;
   bit m_err;
   int m_stack[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit exp_ct(input logic [3:0] c, input int sel, input bit inv);
      bit b;
      b = (sel < COND_N) ? c[sel] : 1'b0;
      return b ^ inv;
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_err   = 1'b0;
      m_stack.delete();
   endtask

   // Reference behaviour expressed directly from the mode table.
   task automatic model_next(input int mode, input bit ct, input int tgt, input int enc);
      int inc;
      inc = (m_state + 1) % (1 << STATE_W);
      case (mode)
         0: m_state = enc;
         1: m_state = inc;
         2: m_state = ct ? tgt : inc;
         3: m_state = ct ? enc : inc;
         4: begin
            if (!ct) m_state = inc;
            else if (m_stack.size() == DEPTH) begin m_state = inc; m_err = 1'b1; end
            else begin m_stack.push_back(inc); m_state = tgt; end
         end
         5: begin
            if (m_stack.size() == 0) begin m_state = 0; m_err = 1'b1; end
            else m_state = m_stack.pop_back();
         end
         default: begin m_state = inc; m_err = 1'b1; end
      endcase
   endtask

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("state", 32'(bus.state), 32'(m_state));
         check("depth", 32'(bus.depth), 32'(m_stack.size()));
         check("err", 32'(bus.err), 32'(m_err));
         check("cond_true", 32'(bus.cond_true),
               32'(exp_ct(bus.cond, int'(bus.cond_sel), bus.cond_inv)));
      end
   end

   task automatic step(input logic [2:0] mode, input logic [3:0] c, input logic [1:0] sel,
                       input logic inv, input logic [6:0] tgt, input logic [6:0] enc,
                       input logic stl);
      @(negedge clk);
      #1;
      bus.ns_mode   = mode;
      bus.cond      = c;
      bus.cond_sel  = sel;
      bus.cond_inv  = inv;
      bus.target    = tgt;
      bus.enc_state = enc;
      bus.stall     = stl;
      if (!stl) model_next(int'(mode), exp_ct(c, int'(sel), inv), int'(tgt), int'(enc));
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #3;
      bus.stall = 1'b1;
      rst_n     = 1'b0;
      model_reset();
      #1;
      check("rst_state", 32'(bus.state), 32'h0);
      check("rst_depth", 32'(bus.depth), 32'h0);
      check("rst_err", 32'(bus.err), 32'h0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.stall     = 1'b1;
      bus.ns_mode   = 3'd1;
      bus.cond      = 4'b0000;
      bus.cond_sel  = 2'd0;
      bus.cond_inv  = 1'b0;
      bus.target    = 7'h00;
      bus.enc_state = 7'h00;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;

      step(3'd0, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h25, 1'b0);
      check("lit_enc25", 32'(bus.state), 32'h25);
      do_reset();
      step(3'd1, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h00, 1'b0);
      check("lit_inc1", 32'(bus.state), 32'h01);
      step(3'd1, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h00, 1'b0);
      check("lit_inc2", 32'(bus.state), 32'h02);
      step(3'd1, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h00, 1'b0);
      check("lit_inc3", 32'(bus.state), 32'h03);

      step(3'd2, 4'b0100, 2'd2, 1'b0, 7'h40, 7'h00, 1'b0);
      check("lit_cjump_taken", 32'(bus.state), 32'h40);
      step(3'd2, 4'b0100, 2'd2, 1'b1, 7'h40, 7'h00, 1'b0);
      check("lit_cjump_inv", 32'(bus.state), 32'h41);
      check("lit_ct_inv", 32'(bus.cond_true), 32'h0);
      step(3'd2, 4'b0100, 2'd2, 1'b0, 7'h7F, 7'h00, 1'b0);
      step(3'd1, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h00, 1'b0);
      check("lit_wrap", 32'(bus.state), 32'h00);
      step(3'd0, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h11, 1'b0);
      check("lit_enc11", 32'(bus.state), 32'h11);
      step(3'd3, 4'b1000, 2'd3, 1'b0, 7'h00, 7'h22, 1'b0);
      check("lit_cenc_taken", 32'(bus.state), 32'h22);
      step(3'd3, 4'b1000, 2'd0, 1'b0, 7'h00, 7'h55, 1'b0);
      check("lit_cenc_not", 32'(bus.state), 32'h23);

      step(3'd0, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h10, 1'b0);
      step(3'd4, 4'b0100, 2'd2, 1'b0, 7'h30, 7'h00, 1'b0);
      check("lit_call_state", 32'(bus.state), 32'h30);
      check("lit_call_depth", 32'(bus.depth), 32'h1);
      step(3'd5, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h00, 1'b0);
      check("lit_ret_state", 32'(bus.state), 32'h11);
      check("lit_ret_depth", 32'(bus.depth), 32'h0);
      step(3'd4, 4'b0100, 2'd0, 1'b0, 7'h30, 7'h00, 1'b0);
      check("lit_call_not", 32'(bus.state), 32'h12);
      step(3'd4, 4'b0100, 2'd2, 1'b0, 7'h50, 7'h00, 1'b0);
      step(3'd4, 4'b0100, 2'd2, 1'b0, 7'h60, 7'h00, 1'b0);
      check("lit_nest_depth", 32'(bus.depth), 32'h2);
      step(3'd4, 4'b0100, 2'd2, 1'b0, 7'h70, 7'h00, 1'b0);
      check("lit_ovf_state", 32'(bus.state), 32'h61);
      check("lit_ovf_err", 32'(bus.err), 32'h1);
      check("lit_ovf_depth", 32'(bus.depth), 32'h2);
      step(3'd5, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h00, 1'b0);
      check("lit_pop1", 32'(bus.state), 32'h51);
      step(3'd5, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h00, 1'b0);
      check("lit_pop2", 32'(bus.state), 32'h13);

      do_reset();
      step(3'd0, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h33, 1'b0);
      step(3'd5, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h00, 1'b0);
      check("lit_udf_state", 32'(bus.state), 32'h00);
      check("lit_udf_err", 32'(bus.err), 32'h1);
      step(3'd4, 4'b0100, 2'd2, 1'b0, 7'h20, 7'h00, 1'b0);
      step(3'd2, 4'b0100, 2'd2, 1'b0, 7'h40, 7'h00, 1'b1);
      check("lit_stall_state", 32'(bus.state), 32'h20);
      check("lit_stall_depth", 32'(bus.depth), 32'h1);
      check("lit_stall_ct", 32'(bus.cond_true), 32'h1);
      step(3'd5, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h00, 1'b1);
      check("lit_stall_ret", 32'(bus.depth), 32'h1);
      step(3'd5, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h00, 1'b0);
      check("lit_ret_after_stall", 32'(bus.state), 32'h01);

      do_reset();
      step(3'd6, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h00, 1'b1);
      check("lit_stall_rsv_err", 32'(bus.err), 32'h0);
      step(3'd0, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h05, 1'b0);
      step(3'd6, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h00, 1'b0);
      check("lit_rsv6_state", 32'(bus.state), 32'h06);
      check("lit_rsv6_err", 32'(bus.err), 32'h1);
      step(3'd7, 4'b0000, 2'd0, 1'b0, 7'h00, 7'h00, 1'b0);
      check("lit_rsv7_state", 32'(bus.state), 32'h07);

      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cu_microsequencer.md
# cu_microsequencer

Parametrised next-state sequencer for the ARM simulator control unit: replaces the fixed 4-to-1 condition mux, condition inverter and 7-bit next-state select with a registered state machine that picks a condition input, optionally inverts it, and chooses the next control state. It also supports microcode subroutine call/return through a small LIFO. The sequencer sits between the microcode ROM, which supplies the mode, condition select, inversion and target fields, and the state register that addresses that ROM.

## Interface
- STATE_W, 7, width of the control state
- COND_N, 4, number of condition inputs
- STACK_DEPTH, 2, return-address LIFO entries (1 or more)
- RESET_STATE, 0, state loaded on reset
- clk  input  1  clock, rising edge
- rst_n  input  1  reset; one clock domain, asynchronous assertion, active-low
- stall  input  1  hold state, stack and err
- cond  input  COND_N  condition flags (status, MOC, etc.)
- cond_sel  input  max(1,$clog2(COND_N))  condition index from ROM
- cond_inv  input  1  invert selected condition
- ns_mode  input  3  next-state mode from ROM
- target  input  STATE_W  jump/call target from ROM
- enc_state  input  STATE_W  instruction-decoder entry state
- state  output  STATE_W  current control state (registered)
- cond_true  output  1  selected condition after inversion (combinational)
- depth  output  $clog2(STACK_DEPTH+1)  stack occupancy
- err  output  1  sticky stack overflow/underflow flag

## Operation
- cond_true = cond[cond_sel] ^ cond_inv; a cond_sel of COND_N or more selects 0 before inversion.
- inc = state + 1 mod 2^STATE_W, so the maximum state wraps to 0.
- ns_mode 0 ENCODE: next = enc_state.
- ns_mode 1 INC: next = inc.
- ns_mode 2 CJUMP: next = cond_true ? target : inc.
- ns_mode 3 CENC: next = cond_true ? enc_state : inc.
- ns_mode 4 CALL: if cond_true, push inc and next = target; otherwise next = inc.
- ns_mode 5 RET: pop, and next = the popped value.
- ns_mode 6 and 7 are reserved: they behave as INC and set err.
- CALL with cond_true while depth == STACK_DEPTH: no push, next = inc, err is set.
- RET with depth == 0: no pop, next = RESET_STATE, err is set.
- err is cleared only by reset.
- stall = 1 freezes state, the stack, depth and err; cond_true still tracks its inputs.

## Timing
- Next-state logic is combinational from the current inputs and state. state updates on the rising edge of clk, one cycle after the ROM fields are presented.
- Reset values: state = RESET_STATE, depth = 0, err = 0. Stack contents are don't-care.
- rst_n asserted mid-sequence clears state, depth and err immediately, with no clock required. The first update after release occurs on the first rising edge with rst_n high.
- Push and the state load happen on the same edge. A popped value is visible on state the edge after RET is presented.
- CALL immediately followed by RET returns to call-site+1 with no bubble.

## Structure
- Shared package cu_pkg holds the ns_mode constants (NS_ENCODE … NS_RET), the reserved-mode range, and a function computing the cond_sel width.
- Sub-module cu_ret_stack: a LIFO of STACK_DEPTH × STATE_W with push, pop, top, depth, full and empty. It is asynchronous-reset with rst_n and has no error logic; the sequencer owns err.
- The condition select and inversion stay inline. The separate inverter and mux modules are not instantiated.

## Test plan
- Reset and branch: rst_n low mid-run with state = 0x25 → state = 0, depth = 0, err = 0 with no clock edge. Release, then ns_mode = 1 for three edges → state 1, 2, 3.
- Conditional jump: cond = 4'b0100, cond_sel = 2, cond_inv = 0, mode CJUMP, target = 0x40 → 0x40. Repeat with cond_inv = 1 → inc.
- Wrap: state = 0x7F with INC → 0x00. ENCODE with enc_state = 0x11 → 0x11.
- Call/return: from state 0x10, CALL target 0x30 → state 0x30, depth 1. RET → 0x11, depth 0. Nested CALLs beyond STACK_DEPTH = 2 → third call gives inc, err = 1, depth stays 2.
- Underflow and stall: RET at depth 0 → state = RESET_STATE, err = 1. stall = 1 with CJUMP taken → state, depth and err unchanged. Reserved mode 6 → inc with err = 1.
